// File: rtl/spi_master_mode.sv
// SPI master covering all four CPOL/CPHA modes, with per-frame divider latching and held selects.
// Define SPI_LSB_FIRST_EN to add the lsb_first port for LSB-first framing.
module spi_master_mode #(
  parameter int DW     = 8,
  parameter int DVSR_W = 16,
  parameter int NUM_SS = 1,
  parameter int SS_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW-1:0]     din,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              ss_hold,
  input  logic              ss_release,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              wr_sd,
  input  logic              spi_miso,
  output logic [DW-1:0]     dout,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic [NUM_SS-1:0] spi_ss_n,
  output logic              spi_done_tick,
  output logic              spi_idle
);

  localparam int BIT_W = $clog2(DW);

  typedef enum logic [2:0] {IDLE, SETUP, P0, P1, HOLD} state_t;

  state_t            state;
  logic [DVSR_W-1:0] cnt;
  logic [DVSR_W-1:0] dvsr_reg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DW-1:0]     tx_reg;
  logic [DW-1:0]     rx_reg;
  logic [DW-1:0]     tx_shift;
  logic [DW-1:0]     rx_shift;
  logic [SS_W-1:0]   sel_reg;
  logic              cpol_reg;
  logic              cpha_reg;
  logic              hold_reg;
  logic              held;
  logic              cnt_last;
  logic              last_bit;

  // A divider of 0 behaves like 1: every non-idle state lasts at least one cycle.
  assign cnt_last = (dvsr_reg <= DVSR_W'(1)) || (cnt == dvsr_reg - DVSR_W'(1));
  assign last_bit = (bit_cnt == BIT_W'(DW - 1));
  assign spi_idle = (state == IDLE);

`ifdef SPI_LSB_FIRST_EN
  logic lsb_reg;
  assign tx_shift = lsb_reg ? {1'b0, tx_reg[DW-1:1]} : {tx_reg[DW-2:0], 1'b0};
  assign rx_shift = lsb_reg ? {spi_miso, rx_reg[DW-1:1]} : {rx_reg[DW-2:0], spi_miso};
  assign spi_mosi = lsb_reg ? tx_reg[0] : tx_reg[DW-1];
`else
  assign tx_shift = {tx_reg[DW-2:0], 1'b0};
  assign rx_shift = {rx_reg[DW-2:0], spi_miso};
  assign spi_mosi = tx_reg[DW-1];
`endif

  function automatic logic [NUM_SS-1:0] sel_decode(input logic [SS_W-1:0] s);
    logic [NUM_SS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (s == SS_W'(i)) r[i] = 1'b0;
    end
    return r;
  endfunction

  // spi_clk is assigned alongside each transition so it lines up with the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      dvsr_reg      <= '0;
      bit_cnt       <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      dout          <= '0;
      sel_reg       <= '0;
      cpol_reg      <= 1'b0;
      cpha_reg      <= 1'b0;
      hold_reg      <= 1'b0;
      held          <= 1'b0;
      spi_clk       <= 1'b0;
      spi_ss_n      <= '1;
      spi_done_tick <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
      lsb_reg       <= 1'b0;
`endif
    end else begin
      spi_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          spi_clk <= cpol;
          if (wr_sd) begin
            dvsr_reg <= dvsr;
            cpol_reg <= cpol;
            cpha_reg <= cpha;
            sel_reg  <= ss_sel;
            hold_reg <= ss_hold;
            tx_reg   <= din;
            rx_reg   <= '0;
            held     <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
            lsb_reg  <= lsb_first;
`endif
            // Re-addressing the held slave skips setup; any other target swaps selects at once.
            if (held && (ss_sel == sel_reg)) begin
              state <= P0;
            end else begin
              state    <= SETUP;
              spi_ss_n <= sel_decode(ss_sel);
            end
          end else if (ss_release && held) begin
            spi_ss_n <= '1;
            held     <= 1'b0;
          end
        end

        SETUP: begin
          if (cnt_last) begin
            cnt     <= '0;
            state   <= P0;
            spi_clk <= cpol_reg;
          end else begin
            cnt <= cnt + DVSR_W'(1);
          end
        end

        P0: begin
          if (cnt_last) begin
            cnt     <= '0;
            state   <= P1;
            spi_clk <= ~cpol_reg;
            if (!cpha_reg) rx_reg <= rx_shift;
            else if (bit_cnt != '0) tx_reg <= tx_shift;
          end else begin
            cnt <= cnt + DVSR_W'(1);
          end
        end

        P1: begin
          if (cnt_last) begin
            cnt     <= '0;
            spi_clk <= cpol_reg;
            if (cpha_reg) rx_reg <= rx_shift;
            if (!last_bit) begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              state   <= P0;
              if (!cpha_reg) tx_reg <= tx_shift;
            end else begin
              spi_done_tick <= 1'b1;
              dout          <= cpha_reg ? rx_shift : rx_reg;
              if (hold_reg) begin
                state <= IDLE;
                held  <= 1'b1;
              end else begin
                state <= HOLD;
              end
            end
          end else begin
            cnt <= cnt + DVSR_W'(1);
          end
        end

        HOLD: begin
          if (cnt_last) begin
            cnt      <= '0;
            state    <= IDLE;
            spi_ss_n <= '1;
          end else begin
            cnt <= cnt + DVSR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_mode.sv
// Directed self-checking bench for spi_master_mode (DW=8, NUM_SS=4).
`timescale 1ns/1ps
module tb_spi_master_mode;

  localparam int DW     = 8;
  localparam int DVSR_W = 16;
  localparam int NUM_SS = 4;
  localparam int SS_W   = 4;

  logic              clk;
  logic              reset;
  logic [DW-1:0]     din;
  logic [DVSR_W-1:0] dvsr;
  logic              cpol;
  logic              cpha;
  logic [SS_W-1:0]   ss_sel;
  logic              ss_hold;
  logic              ss_release;
  logic              wr_sd;
  wire               spi_miso;
  logic [DW-1:0]     dout;
  logic              spi_clk;
  logic              spi_mosi;
  logic [NUM_SS-1:0] spi_ss_n;
  logic              spi_done_tick;
  logic              spi_idle;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first;
`endif

  logic       loopback;
  logic       slv_en;
  logic       slv_cpol;
  logic       slv_cpha;
  logic [7:0] slv_data;
  logic       slv_miso;
  logic       slv_prev;
  int         slv_idx;

  int checks = 0;
  int errors = 0;

  assign spi_miso = loopback ? spi_mosi : slv_miso;

  spi_master_mode #(.DW(DW), .DVSR_W(DVSR_W), .NUM_SS(NUM_SS), .SS_W(SS_W)) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .dvsr(dvsr),
    .cpol(cpol),
    .cpha(cpha),
    .ss_sel(ss_sel),
    .ss_hold(ss_hold),
    .ss_release(ss_release),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .wr_sd(wr_sd),
    .spi_miso(spi_miso),
    .dout(dout),
    .spi_clk(spi_clk),
    .spi_mosi(spi_mosi),
    .spi_ss_n(spi_ss_n),
    .spi_done_tick(spi_done_tick),
    .spi_idle(spi_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave on select 0: shifts slv_data out MSB-first on the edge opposite to the master's sample edge.
  always @(spi_clk or spi_ss_n[0]) begin
    if (spi_ss_n[0] || !slv_en) begin
      slv_idx  <= 7;
      slv_miso <= slv_cpha ? 1'b0 : slv_data[7];
    end else if (spi_clk != slv_prev) begin
      if (spi_clk != slv_cpol) begin
        if (slv_cpha && slv_idx >= 0) begin
          slv_miso <= slv_data[slv_idx];
          slv_idx  <= slv_idx - 1;
        end
      end else begin
        if (!slv_cpha && slv_idx > 0) begin
          slv_miso <= slv_data[slv_idx-1];
          slv_idx  <= slv_idx - 1;
        end
      end
    end
    slv_prev <= spi_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [15:0] dv, input logic pol,
                               input logic pha, input logic [3:0] sel, input logic hold);
    din     = d;
    dvsr    = dv;
    cpol    = pol;
    cpha    = pha;
    ss_sel  = sel;
    ss_hold = hold;
    wr_sd   = 1'b1;
  endtask

  // Issues one frame (accepted at cycle 0) and records event cycles until spi_idle returns.
  task automatic doFrame(input logic [7:0] d, input logic [15:0] dv, input logic pol, input logic pha,
                         input logic [3:0] sel, input logic hold, input int inject,
                         output int done_cyc, output int idle_cyc, output int rises, output int first_rise,
                         output int ss_low_cyc, output int done_cnt,
                         output logic [3:0] ss_c1, output logic [3:0] ss_end);
    logic prev_clk;
    done_cyc = -1; idle_cyc = -1; rises = 0; first_rise = -1; ss_low_cyc = -1; done_cnt = 0;
    ss_c1 = 4'hx; ss_end = 4'hx;
    @(negedge clk);
    applyStimulus(d, dv, pol, pha, sel, hold);
    prev_clk = spi_clk;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == 1) ss_c1 = spi_ss_n;
      if (ss_low_cyc < 0 && spi_ss_n != 4'hF) ss_low_cyc = k;
      if (spi_done_tick) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (!prev_clk && spi_clk) begin
        rises++;
        if (first_rise < 0) first_rise = k;
      end
      prev_clk = spi_clk;
      wr_sd  = (k == inject);
      din    = (k == inject) ? 8'h00 : d;
      ss_sel = (k == inject) ? 4'd3 : sel;
      if (spi_idle) begin
        idle_cyc = k;
        ss_end   = spi_ss_n;
        break;
      end
    end
    wr_sd = 1'b0;
  endtask

  initial begin
    int dc, ic, rs, fr, sl, dn, post_dn;
    logic [3:0] s1, se;
    logic [1:0] mm;

    reset = 1'b1; din = '0; dvsr = '0; cpol = 1'b0; cpha = 1'b0; ss_sel = '0;
    ss_hold = 1'b0; ss_release = 1'b0; wr_sd = 1'b0; loopback = 1'b1;
    slv_en = 1'b0; slv_cpol = 1'b0; slv_cpha = 1'b0; slv_data = 8'h3C;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_idle", 32'(spi_idle), 32'd1);
    checkOutput("rst_ss_n", 32'(spi_ss_n), 32'hF);
    checkOutput("rst_sclk", 32'(spi_clk), 32'd0);
    checkOutput("rst_mosi", 32'(spi_mosi), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_done", 32'(spi_done_tick), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] mode 0 loopback, dvsr=4, din=0xA5, stray wr_sd at cycle 20");
    doFrame(8'hA5, 16'd4, 1'b0, 1'b0, 4'd0, 1'b0, 20, dc, ic, rs, fr, sl, dn, s1, se);
    checkOutput("m0_ss_low", sl, 1);
    checkOutput("m0_first_rise", fr, 9);
    checkOutput("m0_rises", rs, 8);
    checkOutput("m0_done_cyc", dc, 69);
    checkOutput("m0_done_cnt", dn, 1);
    checkOutput("m0_idle_cyc", ic, 73);
    checkOutput("m0_ss_end", 32'(se), 32'hF);
    checkOutput("m0_dout", 32'(dout), 32'hA5);

    $display("[TB] modes 1..3 against slave returning 0x3C, dvsr=2");
    loopback = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      mm = 2'(m);
      @(negedge clk);
      cpol = mm[1]; cpha = mm[0];
      slv_cpol = mm[1]; slv_cpha = mm[0]; slv_en = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput($sformatf("m%0d_idle_sclk", m), 32'(spi_clk), 32'(mm[1]));
      doFrame(8'h96, 16'd2, mm[1], mm[0], 4'd0, 1'b0, 0, dc, ic, rs, fr, sl, dn, s1, se);
      checkOutput($sformatf("m%0d_dout", m), 32'(dout), 32'h3C);
      checkOutput($sformatf("m%0d_done_cyc", m), dc, 35);
      checkOutput($sformatf("m%0d_idle_cyc", m), ic, 37);
      checkOutput($sformatf("m%0d_first_rise", m), fr, mm[1] ? 7 : 5);
      checkOutput($sformatf("m%0d_rises", m), rs, 8);
      slv_en = 1'b0;
    end
    loopback = 1'b1;
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] dvsr 0 and 1 give one-cycle half periods");
    for (int v = 0; v <= 1; v++) begin
      doFrame(8'h5A, 16'(v), 1'b0, 1'b0, 4'd0, 1'b0, 0, dc, ic, rs, fr, sl, dn, s1, se);
      checkOutput($sformatf("dv%0d_done_cyc", v), dc, 18);
      checkOutput($sformatf("dv%0d_idle_cyc", v), ic, 19);
      checkOutput($sformatf("dv%0d_first_rise", v), fr, 3);
      checkOutput($sformatf("dv%0d_dout", v), 32'(dout), 32'h5A);
    end

    $display("[TB] held select 2 across two frames, then release");
    doFrame(8'h11, 16'd1, 1'b0, 1'b0, 4'd2, 1'b1, 0, dc, ic, rs, fr, sl, dn, s1, se);
    checkOutput("holdA_done_cyc", dc, 18);
    checkOutput("holdA_idle_cyc", ic, 18);
    checkOutput("holdA_ss_end", 32'(se), 32'hB);
    repeat (3) @(negedge clk);
    checkOutput("hold_gap_ss", 32'(spi_ss_n), 32'hB);
    doFrame(8'h22, 16'd1, 1'b0, 1'b0, 4'd2, 1'b1, 0, dc, ic, rs, fr, sl, dn, s1, se);
    checkOutput("holdB_first_rise", fr, 2);
    checkOutput("holdB_done_cyc", dc, 17);
    checkOutput("holdB_ss_end", 32'(se), 32'hB);
    checkOutput("holdB_dout", 32'(dout), 32'h22);
    @(negedge clk);
    ss_release = 1'b1;
    @(negedge clk);
    ss_release = 1'b0;
    checkOutput("release_ss", 32'(spi_ss_n), 32'hF);

    $display("[TB] held select 1 swapped for select 3, then out-of-range select 5");
    doFrame(8'h33, 16'd1, 1'b0, 1'b0, 4'd1, 1'b1, 0, dc, ic, rs, fr, sl, dn, s1, se);
    checkOutput("holdC_ss_end", 32'(se), 32'hD);
    doFrame(8'h44, 16'd1, 1'b0, 1'b0, 4'd3, 1'b0, 0, dc, ic, rs, fr, sl, dn, s1, se);
    checkOutput("swap_ss_c1", 32'(s1), 32'h7);
    checkOutput("swap_done_cyc", dc, 18);
    checkOutput("swap_ss_end", 32'(se), 32'hF);
    doFrame(8'h69, 16'd1, 1'b0, 1'b0, 4'd5, 1'b0, 0, dc, ic, rs, fr, sl, dn, s1, se);
    checkOutput("sel5_ss_low", sl, -1);
    checkOutput("sel5_done_cyc", dc, 18);
    checkOutput("sel5_dout", 32'(dout), 32'h69);

    $display("[TB] reset at cycle 30 of a mode 2 frame");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cpol = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_idle_sclk", 32'(spi_clk), 32'd1);
    applyStimulus(8'hFF, 16'd4, 1'b1, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    wr_sd = 1'b0;
    repeat (29) @(negedge clk);
    checkOutput("mid_busy", 32'(spi_idle), 32'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_sclk", 32'(spi_clk), 32'd0);
    checkOutput("arst_mosi", 32'(spi_mosi), 32'd0);
    checkOutput("arst_ss_n", 32'(spi_ss_n), 32'hF);
    checkOutput("arst_idle", 32'(spi_idle), 32'd1);
    checkOutput("arst_done", 32'(spi_done_tick), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    post_dn = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (spi_done_tick) post_dn++;
    end
    checkOutput("arst_no_done", post_dn, 0);
    checkOutput("arst_dout", 32'(dout), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
